seq_stream_monitor: RTL and testbench
=====================================

Name: seq_stream_monitor

Overview:
- Downstream consumer of the 8-bit registered-stage / pass-through chain output.
- Checks that the incoming stream increments by one per valid sample from a START value up to a TARGET value.
- Counts errors and latches a pass/fail verdict for the top-level testbench.
- Built as a hierarchical block, so the top reads its verdict through ports only.

Parameters:
- WIDTH, 8: data width of the monitored stream.
- START, 0: value that arms the monitor.
- TARGET, 15: value that ends a tracking run.
- MAX_ERR, 4: error count at which the monitor gives up and moves to FAIL (range 1..2^ERRW-1).
- ERRW, 4: width of err_count.

Ports:
- clk, input, 1: single clock; all state updates on posedge.
- rst_n, input, 1: reset, asynchronous and active-low.
- clear, input, 1: synchronous return to IDLE; zeroes all counters.
- in_valid, input, 1: in_data is a sample this cycle.
- in_data, input, WIDTH: stream sample from upstream stage.
- done, output, 1: verdict latched (DONE or FAIL).
- pass, output, 1: valid only when done=1; 1 = clean run reached TARGET.
- err_count, output, ERRW: mismatches seen since arming.
- sample_count, output, 16: valid samples accepted since arming.
- last_data, output, WIDTH: last accepted sample.

Behaviour:
- All outputs registered; the effect of a sample is visible the cycle after it is presented (1-cycle latency).
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - done=0, pass=0, err_count=0, sample_count=0, last_data=0.
- States: IDLE, TRACK, DONE, FAIL. Encoding is free and not visible at ports.
- Priority each cycle: rst_n, then clear, then in_valid. in_valid=0 means no state or output change.
- clear=1 from any state:
  - next state IDLE, all outputs zero.
  - a same-cycle valid sample is dropped.
- IDLE:
  - valid with in_data==START: go to TRACK, sample_count=1, last_data=in_data.
  - valid with any other value: ignored; no error, no count.
- TRACK, on each valid sample:
  - expected = (last_data + 1) mod 2^WIDTH, so wrap 2^WIDTH-1 -> 0 is a legal step.
  - sample_count += 1, saturating at 65535.
  - last_data = in_data on every sample, match or not. A mismatch therefore resyncs tracking to the new value.
  - Match and in_data==TARGET: go to DONE, done=1, pass=(err_count==0).
  - Mismatch (including a repeated value): err_count += 1, saturating at 2^ERRW-1.
    - if the new err_count == MAX_ERR: go to FAIL, done=1, pass=0.
    - otherwise stay in TRACK.
  - in_data==TARGET on a mismatch counts as an error only; it does not end the run.
- START==TARGET: the arming sample does not complete a run. Completion needs TARGET reached again through a matching step, i.e. after a full wrap.
- DONE and FAIL:
  - terminal; all outputs held.
  - further valid samples ignored; counters frozen.
  - exit only via clear or rst_n.
- Reset asserted mid-run: outputs go to zero immediately, without waiting for a clock edge. After release, the monitor waits for a fresh START.
- pass is 0 whenever done is 0.

Test Plan:
- Reset then in_valid=1 with values 0,1,...,15 on consecutive cycles -> the cycle after 15: done=1, pass=1, err_count=0, sample_count=16, last_data=15.
- Stream 3,7,0,1,2 in IDLE -> 3 and 7 ignored; after 2: state TRACK, sample_count=3, err_count=0, done=0.
- Stream 0,1,1,2,3,...,15 (duplicate 1) -> err_count=1, resync on the duplicate. At 15: done=1, pass=0, sample_count=17.
- Stream 0,5,9,20,30 -> err_count reaches 4 on 30, giving FAIL with done=1, pass=0. A later 15 leaves all outputs unchanged.
- START=250, TARGET=2, stream 250..255,0,1,2 -> wrap accepted; done=1, pass=1, sample_count=9.
- Mid-run (sample_count=5): assert clear together with in_valid -> next cycle all outputs 0, state IDLE. Separately, pulse rst_n low between clock edges -> outputs 0 without waiting for an edge; a restart from 0 completes normally.

Source files
------------

// File: rtl/seq_stream_monitor.sv
`default_nettype none
// ============================================================================
// Module   : seq_stream_monitor
// Purpose  : Watches an incrementing data stream. A sample equal to START
//            arms the monitor. From then on every valid sample must be the
//            previous one plus one (mod 2^WIDTH). A matching step that lands
//            on TARGET ends the run with a pass/fail verdict. MAX_ERR
//            mismatches end the run early with a fail verdict.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1      clock, all state updates on posedge
//   rst_n        in   1      asynchronous active-low reset
//   clear        in   1      synchronous return to IDLE, zeroes counters
//   in_valid     in   1      in_data carries a sample this cycle
//   in_data      in   WIDTH  stream sample
//   done         out  1      verdict latched (DONE or FAIL)
//   pass         out  1      1 = clean run reached TARGET (only when done)
//   err_count    out  ERRW   mismatches seen since arming (saturating)
//   sample_count out  16     samples accepted since arming (saturating)
//   last_data    out  WIDTH  last accepted sample
// ============================================================================
module seq_stream_monitor #(
    parameter int WIDTH   = 8,
    parameter int START   = 0,
    parameter int TARGET  = 15,
    parameter int MAX_ERR = 4,
    parameter int ERRW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             done,
    output logic             pass,
    output logic [ERRW-1:0]  err_count,
    output logic [15:0]      sample_count,
    output logic [WIDTH-1:0] last_data
);

    localparam logic [WIDTH-1:0] c_start   = WIDTH'(START);
    localparam logic [WIDTH-1:0] c_target  = WIDTH'(TARGET);
    localparam logic [WIDTH-1:0] c_one     = WIDTH'(1);
    localparam logic [ERRW-1:0]  c_max_err = ERRW'(MAX_ERR);
    localparam logic [ERRW-1:0]  c_err_sat = {ERRW{1'b1}};
    localparam logic [15:0]      c_cnt_sat = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TRACK = 2'd1,
        S_DONE  = 2'd2,
        S_FAIL  = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    state_t             r_state;
    logic               r_done;
    logic               r_pass;
    logic [ERRW-1:0]    r_err;
    logic [15:0]        r_cnt;
    logic [WIDTH-1:0]   r_last;

    state_t             w_state_nxt;
    logic               w_done_nxt;
    logic               w_pass_nxt;
    logic [ERRW-1:0]    w_err_nxt;
    logic [15:0]        w_cnt_nxt;
    logic [WIDTH-1:0]   w_last_nxt;

    // Helpers for the TRACK step
    logic [WIDTH-1:0]   w_expect;
    logic               w_match;
    logic [ERRW-1:0]    w_err_inc;
    logic [15:0]        w_cnt_inc;

    // Natural WIDTH-bit truncation makes the 2^WIDTH-1 -> 0 wrap a legal step.
    assign w_expect  = r_last + c_one;
    assign w_match   = (in_data == w_expect);
    assign w_err_inc = (r_err == c_err_sat) ? r_err : r_err + ERRW'(1);
    assign w_cnt_inc = (r_cnt == c_cnt_sat) ? r_cnt : r_cnt + 16'd1;

    // ------------------------------------------------------------------------
    // State register: reset acts immediately, independent of clk.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= '0;
            r_cnt   <= '0;
            r_last  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
            r_pass  <= w_pass_nxt;
            r_err   <= w_err_nxt;
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state / next-output logic. Everything holds unless changed below.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = r_done;
        w_pass_nxt  = r_pass;
        w_err_nxt   = r_err;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;

        if (clear) begin
            // Clear wins over a same-cycle sample, which is simply dropped.
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b0;
            w_pass_nxt  = 1'b0;
            w_err_nxt   = '0;
            w_cnt_nxt   = '0;
            w_last_nxt  = '0;
        end else if (in_valid) begin
            case (r_state)
                S_IDLE: begin
                    // Anything other than START is ignored while unarmed.
                    // Arming never completes a run, even when START==TARGET.
                    if (in_data == c_start) begin
                        w_state_nxt = S_TRACK;
                        w_cnt_nxt   = 16'd1;
                        w_last_nxt  = in_data;
                    end
                end

                S_TRACK: begin
                    w_cnt_nxt  = w_cnt_inc;
                    // Always follow the stream, so a mismatch resyncs tracking
                    // to the new value instead of cascading further errors.
                    w_last_nxt = in_data;
                    if (w_match) begin
                        if (in_data == c_target) begin
                            w_state_nxt = S_DONE;
                            w_done_nxt  = 1'b1;
                            w_pass_nxt  = (r_err == '0);
                        end
                    end else begin
                        // TARGET reached by a bad step is just another error.
                        w_err_nxt = w_err_inc;
                        if (w_err_inc == c_max_err) begin
                            w_state_nxt = S_FAIL;
                            w_done_nxt  = 1'b1;
                            w_pass_nxt  = 1'b0;
                        end
                    end
                end

                // Terminal states: verdict and counters frozen.
                S_DONE, S_FAIL: begin
                    w_state_nxt = r_state;
                end

                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign done         = r_done;
    assign pass         = r_pass;
    assign err_count    = r_err;
    assign sample_count = r_cnt;
    assign last_data    = r_last;

endmodule
`default_nettype wire

// File: tb/tb_seq_stream_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_seq_stream_monitor
// Purpose  : Directed self-checking bench for seq_stream_monitor. A default
//            instance (START=0, TARGET=15) covers the main scenarios; a second
//            instance (START=250, TARGET=2) covers the wrap-around step.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_stream_monitor;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        done;
    logic        pass;
    logic [3:0]  err_count;
    logic [15:0] sample_count;
    logic [7:0]  last_data;

    logic        w_valid;
    logic [7:0]  w_data;
    logic        w_done;
    logic        w_pass;
    logic [3:0]  w_err_count;
    logic [15:0] w_sample_count;
    logic [7:0]  w_last_data;

    int n_checks;
    int n_err;

    seq_stream_monitor #(
        .WIDTH   (8),
        .START   (0),
        .TARGET  (15),
        .MAX_ERR (4),
        .ERRW    (4)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .done         (done),
        .pass         (pass),
        .err_count    (err_count),
        .sample_count (sample_count),
        .last_data    (last_data)
    );

    seq_stream_monitor #(
        .WIDTH   (8),
        .START   (250),
        .TARGET  (2),
        .MAX_ERR (4),
        .ERRW    (4)
    ) u_dut_wrap (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .in_valid     (w_valid),
        .in_data      (w_data),
        .done         (w_done),
        .pass         (w_pass),
        .err_count    (w_err_count),
        .sample_count (w_sample_count),
        .last_data    (w_last_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net: the directed sequence is far shorter than this.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running required finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // All stimulus changes land 1ns after a posedge; checks are made there too.
    task automatic push(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic push_wrap(input logic [7:0] d);
        w_valid = 1'b1;
        w_data  = d;
        @(posedge clk);
        #1;
        w_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic chk_all(input string tag, input logic d, input logic p,
                           input logic [3:0] e, input logic [15:0] c, input logic [7:0] l);
        chk({tag, ".done"},         32'(done),         32'(d));
        chk({tag, ".pass"},         32'(pass),         32'(p));
        chk({tag, ".err_count"},    32'(err_count),    32'(e));
        chk({tag, ".sample_count"}, 32'(sample_count), 32'(c));
        chk({tag, ".last_data"},    32'(last_data),    32'(l));
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        w_valid  = 1'b0;
        w_data   = '0;

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 1'b0, 1'b0, 4'd0, 16'd0, 8'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ---- clean run 0..15 ----
        for (int i = 0; i < 15; i++) push(8'(i));
        chk_all("clean_at14", 1'b0, 1'b0, 4'd0, 16'd15, 8'd14);
        push(8'd15);
        chk_all("clean_done", 1'b1, 1'b1, 4'd0, 16'd16, 8'd15);
        push(8'd16);
        chk_all("clean_hold", 1'b1, 1'b1, 4'd0, 16'd16, 8'd15);

        // ---- non-START values ignored in IDLE ----
        do_clear();
        chk_all("clear1", 1'b0, 1'b0, 4'd0, 16'd0, 8'd0);
        push(8'd3);
        push(8'd7);
        chk_all("idle_ignore", 1'b0, 1'b0, 4'd0, 16'd0, 8'd0);
        push(8'd0);
        push(8'd1);
        push(8'd2);
        chk_all("idle_arm", 1'b0, 1'b0, 4'd0, 16'd3, 8'd2);

        // ---- duplicate value: one error, resync, fail verdict at TARGET ----
        do_clear();
        push(8'd0);
        push(8'd1);
        push(8'd1);
        chk_all("dup_err", 1'b0, 1'b0, 4'd1, 16'd3, 8'd1);
        for (int i = 2; i <= 15; i++) push(8'(i));
        chk_all("dup_done", 1'b1, 1'b0, 4'd1, 16'd17, 8'd15);

        // ---- MAX_ERR mismatches -> FAIL, then frozen ----
        do_clear();
        push(8'd0);
        push(8'd5);
        push(8'd9);
        push(8'd20);
        chk_all("err3", 1'b0, 1'b0, 4'd3, 16'd4, 8'd20);
        push(8'd30);
        chk_all("fail", 1'b1, 1'b0, 4'd4, 16'd5, 8'd30);
        push(8'd31);
        push(8'd15);
        chk_all("fail_hold", 1'b1, 1'b0, 4'd4, 16'd5, 8'd30);

        // ---- clear together with a valid sample mid-run ----
        do_clear();
        for (int i = 0; i < 5; i++) push(8'(i));
        chk_all("pre_clear", 1'b0, 1'b0, 4'd0, 16'd5, 8'd4);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'd5;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        chk_all("clear_valid", 1'b0, 1'b0, 4'd0, 16'd0, 8'd0);
        push(8'd1);
        chk_all("clear_idle", 1'b0, 1'b0, 4'd0, 16'd0, 8'd0);

        // ---- asynchronous reset between edges ----
        push(8'd0);
        push(8'd1);
        push(8'd2);
        chk_all("pre_rst", 1'b0, 1'b0, 4'd0, 16'd3, 8'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 1'b0, 1'b0, 4'd0, 16'd0, 8'd0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push(8'd3);
        chk_all("rst_idle", 1'b0, 1'b0, 4'd0, 16'd0, 8'd0);
        for (int i = 0; i <= 15; i++) push(8'(i));
        chk_all("restart_done", 1'b1, 1'b1, 4'd0, 16'd16, 8'd15);

        // ---- wrap instance: 250..255,0,1,2 ----
        for (int i = 250; i <= 255; i++) push_wrap(8'(i));
        chk("wrap_at255.done", 32'(w_done), 32'd0);
        chk("wrap_at255.last", 32'(w_last_data), 32'd255);
        push_wrap(8'd0);
        chk("wrap_at0.err", 32'(w_err_count), 32'd0);
        chk("wrap_at0.last", 32'(w_last_data), 32'd0);
        push_wrap(8'd1);
        push_wrap(8'd2);
        chk("wrap.done", 32'(w_done), 32'd1);
        chk("wrap.pass", 32'(w_pass), 32'd1);
        chk("wrap.err", 32'(w_err_count), 32'd0);
        chk("wrap.count", 32'(w_sample_count), 32'd9);
        chk("wrap.last", 32'(w_last_data), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
